// File: rtl/result_argmax_pkg.sv
`default_nettype none
// =============================================================================
// result_argmax_pkg : shared defaults and FSM state encoding for result_argmax
// Revision 1.0
// =============================================================================
package result_argmax_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int CELL_AMOUNT_DEF = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/result_argmax_max_tracker.sv
`default_nettype none
// =============================================================================
// max_tracker : running unsigned maximum with index; strict compare keeps first
// Revision 1.0
// =============================================================================
module max_tracker #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cand_value_i,
  input  logic [DATA_WIDTH-1:0] cand_index_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] max_value_o,
  output logic [DATA_WIDTH-1:0] max_index_o
);

  logic [DATA_WIDTH-1:0] max_value_q, max_value_d;
  logic [DATA_WIDTH-1:0] max_index_q, max_index_d;

  always_comb begin
    max_value_d = max_value_q;
    max_index_d = max_index_q;
    if (clear_i) begin
      max_value_d = '0;
      max_index_d = '0;
    end else if (enable_i && (cand_value_i > max_value_q)) begin
      // Strictly greater: equal values never displace an earlier index
      max_value_d = cand_value_i;
      max_index_d = cand_index_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      max_value_q <= max_value_d;
      max_index_q <= max_index_d;
    end
  end

  assign max_value_o = max_value_q;
  assign max_index_o = max_index_q;

endmodule
`default_nettype wire

// File: rtl/result_argmax.sv
`default_nettype none
// =============================================================================
// result_argmax : collects a frame of scaled values and reports the argmax
// Revision 1.0
// =============================================================================
module result_argmax
  import result_argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CELL_AMOUNT = CELL_AMOUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_index,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  in_enable,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_index,
  output logic [DATA_WIDTH-1:0] result_value,
  output logic                  result_valid,
  output logic                  overrun
);

  localparam int                    PTR_W      = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam logic [DATA_WIDTH-1:0] CELLS      = DATA_WIDTH'(CELL_AMOUNT);
  localparam logic [DATA_WIDTH-1:0] LAST_INDEX = DATA_WIDTH'(CELL_AMOUNT - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(CELL_AMOUNT - 1);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] cells_q [CELL_AMOUNT];
  logic [DATA_WIDTH-1:0] cells_d [CELL_AMOUNT];

  logic                  in_range;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  trk_en, trk_clr;
  logic [DATA_WIDTH-1:0] trk_value, trk_index;

  assign in_range = (in_index < CELLS);
  assign wr_ptr   = in_index[PTR_W-1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    cells_d   = cells_q;
    trk_en    = 1'b0;
    trk_clr   = 1'b0;

    // No backpressure: anything outside a legal COLLECT write is lost
    if (in_enable && ((state_q != COLLECT) || !in_range)) overrun_d = 1'b1;

    case (state_q)
      COLLECT: begin
        if (in_enable && in_range) begin
          cells_d[wr_ptr] = in_value;
          if (in_index == LAST_INDEX) begin
            state_d = SCAN;
            ptr_d   = '0;
            trk_clr = 1'b1;
          end
        end
      end
      SCAN: begin
        trk_en = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = DONE;
          ptr_d   = '0;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          cells_d = '{default: '0};
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cells_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cells_q   <= cells_d;
    end
  end

  max_tracker #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .cand_value_i (cells_q[ptr_q]),
    .cand_index_i (DATA_WIDTH'(ptr_q)),
    .enable_i     (trk_en),
    .clear_i      (trk_clr),
    .max_value_o  (trk_value),
    .max_index_o  (trk_index)
  );

  // Tracker holds the final max through DONE; masking keeps outputs 0 otherwise
  assign result_valid = valid_q;
  assign result_value = valid_q ? trk_value : '0;
  assign result_index = valid_q ? trk_index : '0;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire
